// File: rtl/gpio_bank_avmm.sv
// Avalon-MM GPIO bank: debounced inputs with edge capture and a level interrupt,
// plus registered outputs with set/clear access.
module gpio_bank_avmm #(
    parameter int                   IN_WIDTH        = 4,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 16,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_EDGE_CFG = 3'd6;
    localparam logic [2:0] ADDR_PARAM_ID = 3'd7;

    localparam logic [1:0] CFG_RISING  = 2'b00;
    localparam logic [1:0] CFG_FALLING = 2'b01;
    localparam logic [1:0] CFG_BOTH    = 2'b10;

    localparam logic [15:0] CNT_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DEBOUNCE_W = 32'(DEBOUNCE_CYCLES);
    localparam logic [31:0] IN_W       = 32'(IN_WIDTH);
    localparam logic [31:0] OUT_W      = 32'(OUT_WIDTH);
    localparam logic [31:0] PARAM_ID   = {8'h5A, DEBOUNCE_W[7:0], IN_W[7:0], OUT_W[7:0]};

    logic [IN_WIDTH-1:0]  sync_1, sync_2, db, db_d;
    logic [15:0]          cnt [IN_WIDTH];
    logic [OUT_WIDTH-1:0] data_out;
    logic [IN_WIDTH-1:0]  irq_mask, edge_cap, edge_hit, cap_clr;
    logic [1:0]           edge_cfg;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic                 wr_en, rd_en;
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    assign wdata_in     = avs_writedata[IN_WIDTH-1:0];
    assign wdata_out    = avs_writedata[OUT_WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;
    assign wr_en        = avs_write;
    // A simultaneous write wins; the read is dropped and readdata holds.
    assign rd_en        = avs_read & ~avs_write;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= pio_in;
            sync_2 <= sync_1;
        end
    end

    // NOTE: cnt is a small flop array, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (sync_2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= sync_2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        edge_hit = '0;
        case (edge_cfg)
            CFG_RISING:  edge_hit = db & ~db_d;
            CFG_FALLING: edge_hit = ~db & db_d;
            CFG_BOTH:    edge_hit = db ^ db_d;
            default:     edge_hit = '0;
        endcase
    end

    assign cap_clr = (wr_en && avs_address == ADDR_EDGE_CAP) ? wdata_in : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_out <= OUT_RESET;
            irq_mask <= '0;
            edge_cfg <= CFG_RISING;
            edge_cap <= '0;
        end else begin
            if (wr_en) begin
                case (avs_address)
                    ADDR_DATA_OUT: data_out <= wdata_out;
                    ADDR_OUT_SET:  data_out <= data_out | wdata_out;
                    ADDR_OUT_CLR:  data_out <= data_out & ~wdata_out;
                    ADDR_IRQ_MASK: irq_mask <= wdata_in;
                    ADDR_EDGE_CFG: edge_cfg <= avs_writedata[1:0];
                    default: ;
                endcase
            end
            // Set is OR-ed in after the clear so a same-cycle edge survives.
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (avs_address)
            ADDR_DATA_IN:  rd_mux = 32'(db);
            ADDR_DATA_OUT: rd_mux = 32'(data_out);
            ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = 32'(edge_cap);
            ADDR_EDGE_CFG: rd_mux = {30'h0, edge_cfg};
            ADDR_PARAM_ID: rd_mux = PARAM_ID;
            default:       rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (rd_en) begin
            avs_readdata <= rd_mux;
        end
    end

    assign pio_out = data_out;
    assign irq     = |(edge_cap & irq_mask);

endmodule

// File: doc/gpio_bank_avmm.md
GPIO_BANK_AVMM -- requirements
Module: gpio_bank_avmm

Interface
REQ-001 Parameter IN_WIDTH, default 4, number of input channels (range 1..32).
REQ-002 Parameter OUT_WIDTH, default 8, number of output channels (range 1..32).
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, stable cycles needed to accept an input change (range 1..65535).
REQ-004 Parameter OUT_RESET, default 0, DATA_OUT value at reset (OUT_WIDTH bits).
REQ-005 Port clk_clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port pio_in, input, IN_WIDTH, asynchronous external inputs (buttons, switches).
REQ-008 Port pio_out, output, OUT_WIDTH, registered outputs, equal to DATA_OUT.
REQ-009 Port avs_address, input, 3, word register index.
REQ-010 Port avs_read / avs_write, input, 1 each, Avalon-MM read and write strobes.
REQ-011 Port avs_writedata, input, 32, write data.
REQ-012 Port avs_readdata, output, 32, read data, registered.
REQ-013 Port irq, output, 1, level interrupt.

Function
REQ-014 Register map: 0 DATA_IN RO, 1 DATA_OUT RW, 2 OUT_SET WO, 3 OUT_CLR WO, 4 IRQ_MASK RW, 5 EDGE_CAP RW1C, 6 EDGE_CFG RW, 7 PARAM_ID RO.
REQ-015 Read latency is fixed at 1: avs_readdata is valid the cycle after avs_read and holds until the next read.
REQ-016 Register bits above the channel width read 0 and ignore writes; writes to RO or read-only bits have no effect.
REQ-017 Reads of WO registers 2 and 3 return 0.
REQ-018 If avs_read and avs_write are asserted together, the write takes effect and the read is ignored; avs_readdata holds.
REQ-019 OUT_SET write: DATA_OUT <= DATA_OUT | wdata. OUT_CLR write: DATA_OUT <= DATA_OUT & ~wdata. DATA_OUT write loads directly. pio_out changes 1 cycle after the write.
REQ-020 Each input passes through a 2-flop synchroniser (s2) and then a per-channel debouncer holding db and a 16-bit counter.
REQ-021 Debouncer: if s2==db, cnt <= 0. Otherwise, if cnt==DEBOUNCE_CYCLES-1, then db <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes db.
REQ-023 Latency: a pin change first sampled at edge k updates db at edge k+1+DEBOUNCE_CYCLES.
REQ-024 DATA_IN reads return db.
REQ-025 EDGE_CFG[1:0] is global: 00 rising, 01 falling, 10 both, 11 none. Bits [31:2] read 0.
REQ-026 A qualifying db transition sets the matching EDGE_CAP bit on the edge after db changes.
REQ-027 EDGE_CAP write clears each bit written as 1. If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-028 irq = OR over (EDGE_CAP & IRQ_MASK), driven combinationally from registers and free of glitches from inputs.
REQ-029 A mask change affects irq in the cycle after the write; EDGE_CAP bits still capture while masked.
REQ-030 PARAM_ID = {8'h5A, DEBOUNCE_CYCLES[7:0], IN_WIDTH[7:0], OUT_WIDTH[7:0]}.

Reset
REQ-031 When reset_reset_n is low, immediately: DATA_OUT=OUT_RESET, IRQ_MASK=0, EDGE_CAP=0, EDGE_CFG=00, avs_readdata=0, synchronisers/db/cnt=0, irq=0.
REQ-032 Deassertion mid-activity resumes from reset values; an input held high through reset is accepted DEBOUNCE_CYCLES+2 cycles after release and produces a rising edge.

Verification
REQ-033 Write 0xA5 to DATA_OUT, then OUT_SET 0x0F, then OUT_CLR 0x81 -> pio_out = 0xA5, 0xAF, 0x2E, each 1 cycle after its write.
REQ-034 Defaults; pio_in[0] rises at edge k and stays high -> DATA_IN[0]=1 from edge k+17; EDGE_CAP[0]=1 at k+18; irq stays 0 (mask 0).
REQ-035 pio_in[1] pulses high for 10 cycles with D=16 -> DATA_IN and EDGE_CAP unchanged, irq 0.
REQ-036 IRQ_MASK=0x1, EDGE_CFG=10, toggle pin 0 high then low -> irq after each accepted edge; write 0x1 to EDGE_CAP -> irq 0 next cycle.
REQ-037 Issue an EDGE_CAP clear of bit 0 in the same cycle a new edge sets it -> bit remains 1 and irq stays 1.
REQ-038 Assert reset_reset_n low while a debounce count is in progress and pio_out=0xFF -> pio_out=OUT_RESET with no clock; after release, counting restarts from 0; PARAM_ID reads 0x5A100408.
